// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - TL-UL opcodes, UART register map, status bits and sequencer states
package uart_pkg;

   localparam logic [2:0] TL_PUT_FULL        = 3'd0;
   localparam logic [2:0] TL_GET             = 3'd4;
   localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

   localparam logic [3:0] REG_CSR = 4'h0;
   localparam logic [3:0] REG_TX  = 4'h4;
   localparam logic [3:0] REG_RX  = 4'h8;

   localparam int STAT_TXEMPTY = 18;
   localparam int STAT_TXFULL  = 17;
   localparam int STAT_RXEMPTY = 16;
   localparam int STAT_RXFULL  = 15;

   typedef enum logic [2:0] {
      CFG_REQ,
      CFG_RSP,
      IDLE,
      POLL_REQ,
      POLL_RSP,
      PUT_REQ,
      PUT_RSP
   } seq_state_e;

   function automatic logic is_req_state(seq_state_e s);
      return (s == CFG_REQ) || (s == POLL_REQ) || (s == PUT_REQ);
   endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// rtl/uart_tx_sequencer_if.sv - TL-UL A/D channel bundle between the sequencer and the UART
interface uart_tx_sequencer_if #(
   parameter int TL_RS = 4,
   parameter int TL_SZ = 4
);
   logic [2:0]       a_opcode;
   logic [2:0]       a_param;
   logic [TL_SZ-1:0] a_size;
   logic [TL_RS-1:0] a_source;
   logic [3:0]       a_address;
   logic [3:0]       a_mask;
   logic [31:0]      a_data;
   logic             a_corrupt;
   logic             a_valid;
   logic             a_ready;
   logic [2:0]       d_opcode;
   logic [1:0]       d_param;
   logic [TL_SZ-1:0] d_size;
   logic [TL_RS-1:0] d_source;
   logic             d_denied;
   logic [31:0]      d_data;
   logic             d_corrupt;
   logic             d_valid;
   logic             d_ready;

   modport master (
      output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
      input  a_ready,
      input  d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
      output d_ready
   );

   modport slave (
      input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
      output a_ready,
      output d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
      input  d_ready
   );
endinterface

// File: rtl/seq_byte_fifo.sv
// rtl/seq_byte_fifo.sv - byte FIFO with wrap-around pointers; accepts a push into a full FIFO on a pop
module seq_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   output logic       push_ready_o,
   input  logic       pop_i,
   output logic [7:0] head_o,
   output logic       empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  mem_q [DEPTH];
   logic [7:0]  mem_d [DEPTH];
   logic        full;
   logic        do_pop;
   logic        do_push;

   assign empty_o      = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop       = pop_i && !empty_o;
   assign push_ready_o = !full || do_pop;
   assign do_push      = push_i && push_ready_o;
   assign head_o       = mem_q[rd_ptr_q[AW-1:0]];

   // next storage and pointer values for this cycle's push/pop
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // storage and pointer registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - drains a byte FIFO into a TL-UL UART: CSR setup, txfull polling, TX writes
import uart_pkg::*;

module uart_tx_sequencer #(
   parameter int          TL_RS    = 4,
   parameter int          TL_SZ    = 4,
   parameter int          SRC_ID   = 0,
   parameter int          DEPTH    = 4,
   parameter logic [14:0] CSR_INIT = 15'h0000
) (
   input  logic             seq_clock_i,
   input  logic             seq_reset_ni,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_data_i,
   output logic             byte_ready_o,
   input  logic             cfg_valid_i,
   input  logic [14:0]      cfg_csr_i,
   output logic             cfg_ready_o,
   output logic [2:0]       m_a_opcode,
   output logic [2:0]       m_a_param,
   output logic [TL_SZ-1:0] m_a_size,
   output logic [TL_RS-1:0] m_a_source,
   output logic [3:0]       m_a_address,
   output logic [3:0]       m_a_mask,
   output logic [31:0]      m_a_data,
   output logic             m_a_corrupt,
   output logic             m_a_valid,
   input  logic             m_a_ready,
   input  logic [2:0]       m_d_opcode,
   input  logic [1:0]       m_d_param,
   input  logic [TL_SZ-1:0] m_d_size,
   input  logic [TL_RS-1:0] m_d_source,
   input  logic             m_d_denied,
   input  logic [31:0]      m_d_data,
   input  logic             m_d_corrupt,
   input  logic             m_d_valid,
   output logic             m_d_ready,
   output logic             busy_o,
   output logic             err_o
);
   seq_state_e  state_q, state_d;
   logic [14:0] csr_q, csr_d;
   logic        err_q, err_d;
   logic        a_valid_q, a_valid_d;
   logic        fifo_pop;
   logic        fifo_empty;
   logic [7:0]  fifo_head;
   logic        d_bad;
   logic        unused_d;

   // Only the txfull bit of a response carries information for this block.
   assign unused_d = ^{m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_data[31:18], m_d_data[16:0]};

   seq_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (seq_clock_i),
      .rst_ni       (seq_reset_ni),
      .push_i       (byte_valid_i),
      .push_data_i  (byte_data_i),
      .push_ready_o (byte_ready_o),
      .pop_i        (fifo_pop),
      .head_o       (fifo_head),
      .empty_o      (fifo_empty)
   );

   assign m_d_ready   = (state_q == CFG_RSP) || (state_q == POLL_RSP) || (state_q == PUT_RSP);
   assign d_bad       = m_d_denied || m_d_corrupt;
   assign m_a_valid   = a_valid_q;
   assign m_a_param   = 3'd0;
   assign m_a_corrupt = 1'b0;
   assign m_a_source  = TL_RS'(SRC_ID);
   assign busy_o      = (state_q != IDLE) || !fifo_empty;
   assign err_o       = err_q;

   // next state, CSR capture, sticky error and FIFO pop; a_valid is registered from the next state
   always_comb begin
      state_d     = state_q;
      csr_d       = csr_q;
      err_d       = err_q;
      cfg_ready_o = 1'b0;
      fifo_pop    = 1'b0;
      unique case (state_q)
         CFG_REQ:  if (a_valid_q && m_a_ready) state_d = CFG_RSP;
         CFG_RSP:  if (m_d_valid) state_d = IDLE;
         IDLE: begin
            if (cfg_valid_i) begin
               cfg_ready_o = 1'b1;
               csr_d       = cfg_csr_i;
               state_d     = CFG_REQ;
            end else if (!fifo_empty) begin
               state_d = POLL_REQ;
            end
         end
         POLL_REQ: if (a_valid_q && m_a_ready) state_d = POLL_RSP;
         POLL_RSP: begin
            if (m_d_valid) begin
               if (d_bad)                     state_d = IDLE;
               else if (m_d_data[STAT_TXFULL]) state_d = POLL_REQ;
               else                           state_d = PUT_REQ;
            end
         end
         PUT_REQ:  if (a_valid_q && m_a_ready) state_d = PUT_RSP;
         PUT_RSP: begin
            if (m_d_valid) begin
               fifo_pop = 1'b1;
               state_d  = IDLE;
            end
         end
         default:  state_d = CFG_REQ;
      endcase
      if (m_d_ready && m_d_valid && d_bad) err_d = 1'b1;
      a_valid_d = is_req_state(state_d);
   end

   // A-channel payload depends only on state, the CSR register and the FIFO head
   always_comb begin
      m_a_opcode  = TL_GET;
      m_a_address = REG_CSR;
      m_a_mask    = 4'hF;
      m_a_size    = TL_SZ'(2);
      m_a_data    = 32'h0;
      case (state_q)
         CFG_REQ: begin
            m_a_opcode = TL_PUT_FULL;
            m_a_data   = {17'h0, csr_q};
         end
         PUT_REQ: begin
            m_a_opcode  = TL_PUT_FULL;
            m_a_address = REG_TX;
            m_a_mask    = 4'h1;
            m_a_size    = TL_SZ'(0);
            m_a_data    = {24'h0, fifo_head};
         end
         default: ;
      endcase
   end

   // state, CSR, error and A-valid registers
   always_ff @(posedge seq_clock_i or negedge seq_reset_ni) begin
      if (!seq_reset_ni) begin
         state_q   <= CFG_REQ;
         csr_q     <= CSR_INIT;
         err_q     <= 1'b0;
         a_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         csr_q     <= csr_d;
         err_q     <= err_d;
         a_valid_q <= a_valid_d;
      end
   end
endmodule
